// File: rtl/pixel_readout_buffer_if.sv
// ---------------------------------------------------------------------------
// pixel_readout_buffer_if
//   Output sample stream of the pixel readout buffer (valid/ready).
//   master : drives out_data / out_idx / out_sof / out_valid, samples out_ready
//   slave  : consumer side
// Ports (signals):
//   out_data  [DATA_W]  head sample value
//   out_idx   [IDX_W]   pixel index of the head sample
//   out_sof   1         head sample is pixel 0 of a frame
//   out_valid 1         a sample is presented
//   out_ready 1         consumer accepts the head on valid & ready
// ---------------------------------------------------------------------------
interface pixel_readout_buffer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) ();
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sof;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_idx, output out_sof,
                    output out_valid, input out_ready);
    modport slave  (input out_data, input out_idx, input out_sof,
                    input out_valid, output out_ready);
endinterface

// File: rtl/pixel_readout_buffer.sv
// ---------------------------------------------------------------------------
// pixel_readout_buffer
//   Watches the pixel array's convert strobe and per-pixel read strobes,
//   captures each pixel's value from the shared bus on the falling edge of
//   its read strobe, tags it with pixel index / start-of-frame and queues it
//   in a small FIFO that is drained over a valid/ready stream.
//
// Optional build macro:
//   PIXBUF_BLACKLEVEL_EN  subtract BLACK_LEVEL (saturating at 0) before push.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   convert    ADC convert strobe
//   read_sel   per-pixel read strobes [NUM_PIX]
//   pix_data   shared pixel data bus [DATA_W]
//   out_if     output stream (master modport)
//   fifo_level FIFO occupancy [$clog2(FIFO_DEPTH)+1]
//   overflow   sticky: sample dropped on full FIFO
//   seq_err    sticky: illegal read sequence seen
//   clear_err  synchronous clear of overflow / seq_err
// ---------------------------------------------------------------------------
module pixel_readout_buffer #(
    parameter int                DATA_W      = 8,
    parameter int                NUM_PIX     = 4,
    parameter int                FIFO_DEPTH  = 8,
    parameter logic [DATA_W-1:0] BLACK_LEVEL = '0,
    localparam int               IDX_W       = $clog2(NUM_PIX),
    localparam int               PTR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   convert,
    input  logic [NUM_PIX-1:0]     read_sel,
    input  logic [DATA_W-1:0]      pix_data,
    pixel_readout_buffer_if.master out_if,
    output logic [PTR_W:0]         fifo_level,
    output logic                   overflow,
    output logic                   seq_err,
    input  logic                   clear_err
);
    localparam int ENT_W = 1 + IDX_W + DATA_W;

    typedef enum logic {IDLE, ARMED} state_t;

    // ---------------- input registers ----------------
    logic               conv_q;
    logic [NUM_PIX-1:0] sel_q;
    logic [DATA_W-1:0]  data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conv_q <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            conv_q <= convert;
            sel_q  <= read_sel;
            data_q <= pix_data;
        end
    end

    // ---------------- edge detection ----------------
    logic [NUM_PIX-1:0] fall_vec;
    logic               any_fall, multi_sel, conv_rise, conv_fall;
    logic [IDX_W-1:0]   cap_idx;

    assign fall_vec  = sel_q & ~read_sel;
    assign any_fall  = |fall_vec;
    // A falling strobe while more than one strobe was high is illegal.
    assign multi_sel = any_fall && !$onehot(sel_q);
    assign conv_fall = conv_q & ~convert;
    assign conv_rise = ~conv_q & convert;

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_PIX; i++)
            if (sel_q[i]) cap_idx = IDX_W'(i);
    end

    // ---------------- sample conditioning ----------------
    logic [DATA_W-1:0] push_val;
`ifdef PIXBUF_BLACKLEVEL_EN
    assign push_val = (data_q < BLACK_LEVEL) ? '0 : data_q - BLACK_LEVEL;
`else
    logic [DATA_W-1:0] unused_black_level;
    assign unused_black_level = BLACK_LEVEL;
    assign push_val           = data_q;
`endif

    // ---------------- frame sequencing FSM ----------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] nidx_q, nidx_d;
    logic             push_req, seq_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            nidx_q  <= '0;
        end else begin
            state_q <= state_d;
            nidx_q  <= nidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nidx_d   = nidx_q;
        push_req = 1'b0;
        seq_set  = 1'b0;
        if (multi_sel) begin
            seq_set = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (conv_fall) begin
                        state_d = ARMED;
                        nidx_d  = '0;
                    end
                end
                ARMED: begin
                    if (conv_rise) begin
                        // new conversion before the frame completed
                        seq_set = 1'b1;
                        state_d = IDLE;
                    end else if (any_fall) begin
                        if (cap_idx == nidx_q) begin
                            // pushed even if the FIFO drops it: frame keeps going
                            push_req = 1'b1;
                            if (cap_idx == IDX_W'(NUM_PIX-1)) state_d = IDLE;
                            else nidx_d = nidx_q + IDX_W'(1);
                        end else begin
                            seq_set = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wptr_q, rptr_q, wptr_d, rptr_d;
    logic             full, pop, push_ok, ovf_set, head_valid_d;
    logic [ENT_W-1:0] push_ent, head_d;
    logic             out_valid_q, out_sof_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [DATA_W-1:0] out_data_q;

    assign full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign pop      = out_valid_q & out_if.out_ready;
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign push_ent = {(cap_idx == '0), cap_idx, push_val};
    assign wptr_d   = wptr_q + (PTR_W+1)'(push_ok);
    assign rptr_d   = rptr_q + (PTR_W+1)'(pop);
    // Head register looks at the write pointer before this cycle's push, so
    // a new sample shows up one cycle after it is written and the head slot
    // is never the one being written.
    assign head_valid_d = (wptr_q != rptr_d);
    assign head_d       = mem[rptr_d[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[PTR_W-1:0]] <= push_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_valid_q <= head_valid_d;
            if (head_valid_d) {out_sof_q, out_idx_q, out_data_q} <= head_d;
        end
    end

    // ---------------- sticky flags ----------------
    logic overflow_q, seq_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            // a new error in the same cycle beats clear_err
            overflow_q <= ovf_set | (overflow_q & ~clear_err);
            seq_err_q  <= seq_set | (seq_err_q & ~clear_err);
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_sof   = out_sof_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_data  = out_data_q;
    assign fifo_level       = wptr_q - rptr_q;
    assign overflow         = overflow_q;
    assign seq_err          = seq_err_q;
endmodule

// File: doc/pixel_readout_buffer.md
Name: pixel_readout_buffer

Overview:
- Downstream consumer of the pixel array top level.
- Monitors the per-pixel read strobes and the convert strobe, and captures each pixel's 8-bit value from the shared pixel data bus at the end of its read window.
- Tags each sample with its pixel index and a start-of-frame marker, and queues it in a small FIFO.
- Presents the FIFO contents on a valid/ready stream to the off-chip or serializer interface.

Parameters:
- DATA_W, 8, width of the pixel data bus and of each stored sample.
- NUM_PIX, 4, number of pixels (read strobes) per frame; must be at least 2.
- FIFO_DEPTH, 8, FIFO entry count; power of two, at least 2.
- BLACK_LEVEL, 8'd0, offset subtracted when PIXBUF_BLACKLEVEL_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- convert  in  1  ADC convert strobe from the pixel array.
- read_sel  in  NUM_PIX  read strobes; bit i = read_i.
- pix_data  in  DATA_W  shared pixel data bus, valid while a read strobe is high.
- out_data  out  DATA_W  FIFO head sample.
- out_idx  out  $clog2(NUM_PIX)  pixel index of the head sample.
- out_sof  out  1  head sample is pixel 0 of a frame.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head when out_valid and out_ready are both 1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- seq_err  out  1  sticky: an illegal read sequence was detected.
- clear_err  in  1  synchronous clear of overflow and seq_err.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, next_idx 0.
- Reset mid-frame or mid-transfer discards all queued and partial data.
- Input registering: convert, read_sel and pix_data are registered once per cycle (conv_q, sel_q, data_q).
- Capture event: sel_q has exactly one bit set (i) and read_sel[i] = 0 this cycle, i.e. a falling edge.
  - The captured value is data_q, the bus value from the last cycle of the read window.
- Multiple bits set in sel_q at a falling edge: seq_err <= 1, no capture, FSM -> IDLE.
- FSM states:
  - IDLE: on a convert falling edge (conv_q = 1, convert = 0) -> ARMED with next_idx = 0. Read strobe edges are ignored.
  - ARMED, capture with i == next_idx: push {sof = (i == 0), idx = i, data}.
    - If i == NUM_PIX-1: -> IDLE.
    - Otherwise: next_idx++.
  - ARMED, capture with i != next_idx: seq_err <= 1, no push, -> IDLE.
  - ARMED, convert rising edge: seq_err <= 1 (incomplete frame), -> IDLE; the already-pushed samples stay in the FIFO.
    - The following convert falling edge re-arms normally.
- Latency: a sample appears on out_valid 2 cycles after the falling edge of its read strobe, when the FIFO was empty.
- FIFO pop: on out_valid & out_ready. out_data, out_idx and out_sof are the registered head; the next entry is visible the following cycle.
- Push into a full FIFO:
  - Accepted only if a pop occurs in the same cycle; fifo_level is then unchanged.
  - Otherwise the sample is dropped, overflow <= 1, and the FSM still advances next_idx.
- Push and pop when not full: fifo_level unchanged. Pop when empty: impossible, out_valid = 0.
- Pointer wrap-around: pointers are FIFO_DEPTH-modulo with an extra wrap bit.
- clear_err: clears overflow and seq_err next cycle. If it coincides with a new error, the error wins (flag stays 1).
- Combinational paths: none from inputs to outputs; every output is registered.

Optional Feature:
- Macro: PIXBUF_BLACKLEVEL_EN.
- Defined: the pushed value is data_q - BLACK_LEVEL, saturated at 0 when data_q < BLACK_LEVEL.
- Undefined: data_q is pushed unmodified and BLACK_LEVEL is unused.
- Latency is identical in both builds.

Test Plan:
- Nominal frame: reset low 2 cycles; convert pulse; read0..read3 each 3 cycles high with pix_data 0x11, 0x22, 0x33, 0x44; out_ready = 1 -> four beats, idx 0..3, data 0x11..0x44, out_sof only on idx 0, flags 0.
- Backpressure and overflow (FIFO_DEPTH 8): out_ready = 0, three frames (12 samples) -> fifo_level saturates at 8, overflow = 1. Then out_ready = 1 -> exactly the first 8 samples drain in order, then out_valid = 0.
- Sequence error: convert, then read0 followed by read2 -> one beat (idx 0), seq_err = 1. clear_err -> seq_err = 0. A subsequent good frame delivers 4 beats.
- Simultaneous push/pop at full: fill to 8 with out_ready = 0; assert out_ready in the same cycle as the read3 falling edge -> fifo_level stays 8, no overflow, order preserved.
- Reset mid-frame: assert reset after read1 with 2 entries queued -> out_valid = 0 and fifo_level = 0 immediately (asynchronous). After release, a fresh frame delivers 4 beats starting with out_sof.
- PIXBUF_BLACKLEVEL_EN, BLACK_LEVEL = 0x20: pixels 0x10, 0x20, 0x21, 0xFF -> outputs 0x00, 0x00, 0x01, 0xDF.
